rle_expander: RTL and testbench

Run-length expander stage that sits directly downstream of the run-length encoder datapath in the same pipeline. It accepts (character, repeat-count) pairs through a valid/ready handshake and buffers them in a small FIFO. It replays each character `runIn + 1` times on a valid/ready output stream. Pairs whose character falls outside printable ASCII are discarded and flagged.

---
 rtl/rle_expander.sv | 162 ++++++++++++++++
 tb/tb_rle_expander.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rle_expander.sv
// rle_expander: buffers (character, repeat-count) pairs in a small FIFO and
// replays each character run+1 times on a valid/ready output stream.
// Pairs whose character is not printable ASCII are consumed, dropped and counted.
module rle_expander #(
    parameter int DEPTH = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [6:0] symIn,
    input  logic [7:0] runIn,
    input  logic       inValid,
    output logic       inReady,
    output logic [6:0] dataOut,
    output logic       outValid,
    input  logic       outReady,
    output logic       lastOut,
    output logic       busy,
    output logic       errFlag,
    output logic [7:0] dropCnt
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_e;

    // Pair storage: {sym[6:0], run[7:0]}
    logic [14:0] mem_q [DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;

    state_e      state_q, state_d;
    logic [6:0]  sym_q, sym_d;
    logic [7:0]  rem_q, rem_d;
    logic        err_flag_q, err_flag_d;
    logic [7:0]  drop_cnt_q, drop_cnt_d;

    logic        full_s;
    logic        empty_s;
    logic        sym_ok_s;
    logic        accept_s;
    logic        push_s;
    logic        drop_s;
    logic        pop_s;
    logic [14:0] head_s;

    // Full when indexes match but the wrap bits differ; empty when pointers match.
    assign full_s   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_s  = (wr_ptr_q == rd_ptr_q);
    assign head_s   = mem_q[rd_ptr_q[AW-1:0]];

    assign sym_ok_s = (symIn >= 7'd32) && (symIn <= 7'd126);
    assign accept_s = inValid && inReady;
    assign push_s   = accept_s && sym_ok_s;
    assign drop_s   = accept_s && !sym_ok_s;

    assign inReady  = !full_s && !reset;
    assign outValid = (state_q == ST_EMIT);
    assign dataOut  = sym_q;
    assign lastOut  = (state_q == ST_EMIT) && (rem_q == 8'd0);
    assign busy     = !empty_s || (state_q == ST_EMIT);
    assign errFlag  = err_flag_q;
    assign dropCnt  = drop_cnt_q;

    // Expansion FSM: load a pair when idle, count down copies, chain runs without a bubble.
    always_comb begin
        state_d = state_q;
        sym_d   = sym_q;
        rem_d   = rem_q;
        pop_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!empty_s) begin
                    pop_s   = 1'b1;
                    sym_d   = head_s[14:8];
                    rem_d   = head_s[7:0];
                    state_d = ST_EMIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EMIT: begin
                if (outReady) begin
                    if (rem_q != 8'd0) begin
                        rem_d = rem_q - 8'd1;
                    end else if (!empty_s) begin
                        pop_s = 1'b1;
                        sym_d = head_s[14:8];
                        rem_d = head_s[7:0];
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_EMIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FIFO pointer and drop-accounting next state.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        err_flag_d = err_flag_q;
        drop_cnt_d = drop_cnt_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        if (drop_s) begin
            err_flag_d = 1'b1;
            if (drop_cnt_q != 8'd255) begin
                drop_cnt_d = drop_cnt_q + 8'd1;
            end else begin
                drop_cnt_d = drop_cnt_q;
            end
        end else begin
            err_flag_d = err_flag_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            sym_q      <= 7'd0;
            rem_q      <= 8'd0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            err_flag_q <= 1'b0;
            drop_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            sym_q      <= sym_d;
            rem_q      <= rem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            err_flag_q <= err_flag_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Pair storage write; contents are don't-care once the pointers are reset.
    always_ff @(posedge clock) begin
        if (push_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {symIn, runIn};
        end
    end

endmodule

// File: tb/tb_rle_expander.sv
// Scoreboard bench for rle_expander: accepted pairs expand into expected
// (char, last) entries; every output handshake pops and compares one entry.
module tb_rle_expander;

    localparam int DEPTH = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] symIn = 7'd0;
    logic [7:0] runIn = 8'd0;
    logic       inValid = 1'b0;
    logic       inReady;
    logic [6:0] dataOut;
    logic       outValid;
    logic       outReady = 1'b0;
    logic       lastOut;
    logic       busy;
    logic       errFlag;
    logic [7:0] dropCnt;

    int         total = 0;
    int         bad = 0;
    logic [7:0] exp_q[$];
    int         out_cnt = 0;
    int         exp_drop = 0;
    logic       exp_err = 1'b0;

    rle_expander #(.DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset), .symIn(symIn), .runIn(runIn),
        .inValid(inValid), .inReady(inReady), .dataOut(dataOut),
        .outValid(outValid), .outReady(outReady), .lastOut(lastOut),
        .busy(busy), .errFlag(errFlag), .dropCnt(dropCnt)
    );

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Mid-cycle monitor: the values seen here are what the next rising edge acts on.
    always @(negedge clock) begin
        logic [7:0] e;
        if (reset) begin
            exp_q.delete();
            exp_drop = 0;
            exp_err  = 1'b0;
        end else begin
            check_val("err_flag", 32'(errFlag), 32'(exp_err));
            check_val("drop_cnt", 32'(dropCnt), 32'(exp_drop));
            if (outValid && outReady) begin
                if (exp_q.size() == 0) begin
                    check_val("out_when_sb_empty", 32'(outValid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check_val("data", 32'(dataOut), 32'(e[6:0]));
                    check_val("last", 32'(lastOut), 32'(e[7]));
                end
                out_cnt++;
            end
            if (inValid && inReady) begin
                if (symIn >= 7'd32 && symIn <= 7'd126) begin
                    for (int n = 0; n <= int'(runIn); n++)
                        exp_q.push_back({(n == int'(runIn)), symIn});
                end else begin
                    if (exp_drop < 255) exp_drop++;
                    exp_err = 1'b1;
                end
            end
        end
    end

    // Presents a pair and returns one edge after it is accepted (inValid left high).
    task automatic push(input logic [6:0] s, input logic [7:0] r);
        int w = 0;
        symIn = s;
        runIn = r;
        inValid = 1'b1;
        @(negedge clock);
        while (!inReady && w < 50) begin
            w++;
            @(negedge clock);
        end
        if (!inReady) begin
            check_val("push_timeout", 32'(inReady), 32'd1);
            inValid = 1'b0;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic idle_in();
        inValid = 1'b0;
        symIn = 7'd0;
        runIn = 8'd0;
    endtask

    task automatic wait_idle(input int budget);
        int w = 0;
        while ((busy || exp_q.size() != 0) && w < budget) begin
            @(posedge clock);
            #1;
            w++;
        end
        check_val("drain_busy", 32'(busy), 32'd0);
        check_val("drain_sb", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        logic [6:0] hold_d;
        logic       hold_l;
        int w;

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        check_val("rst_outValid", 32'(outValid), 32'd0);
        check_val("rst_dataOut", 32'(dataOut), 32'd0);
        check_val("rst_lastOut", 32'(lastOut), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_errFlag", 32'(errFlag), 32'd0);
        check_val("rst_dropCnt", 32'(dropCnt), 32'd0);
        check_val("rst_inReady", 32'(inReady), 32'd0);
        reset = 1'b0;
        #1;
        check_val("inReady_after_rst", 32'(inReady), 32'd1);
        @(posedge clock);
        #1;

        // Basic expansion with idle latency
        outReady = 1'b1;
        base = out_cnt;
        push(7'h41, 8'd3);
        idle_in();
        check_val("lat_t_plus_0", 32'(outValid), 32'd0);
        @(posedge clock);
        #1;
        check_val("lat_t_plus_1", 32'(outValid), 32'd1);
        check_val("lat_first_data", 32'(dataOut), 32'h41);
        wait_idle(50);
        check_val("basic_count", 32'(out_cnt - base), 32'd4);

        // Back-to-back runs without bubbles
        @(posedge clock);
        #1;
        base = out_cnt;
        fork
            begin
                push(7'h61, 8'd0);
                push(7'h62, 8'd1);
                push(7'h63, 8'd0);
                idle_in();
            end
            begin
                w = 0;
                @(negedge clock);
                while (!outValid && w < 20) begin
                    w++;
                    @(negedge clock);
                end
                for (int k = 0; k < 4; k++) begin
                    check_val("b2b_valid", 32'(outValid), 32'd1);
                    @(negedge clock);
                end
                check_val("b2b_end_valid", 32'(outValid), 32'd0);
                check_val("b2b_end_busy", 32'(busy), 32'd0);
            end
        join
        @(posedge clock);
        #1;
        check_val("b2b_count", 32'(out_cnt - base), 32'd4);

        // Backpressure and full FIFO
        outReady = 1'b0;
        base = out_cnt;
        push(7'h30, 8'd1);
        push(7'h31, 8'd0);
        push(7'h32, 8'd2);
        push(7'h33, 8'd0);
        push(7'h34, 8'd1);
        idle_in();
        @(negedge clock);
        check_val("full_inReady", 32'(inReady), 32'd0);
        check_val("full_busy", 32'(busy), 32'd1);
        check_val("full_outValid", 32'(outValid), 32'd1);
        check_val("full_head", 32'(dataOut), 32'h30);
        hold_d = dataOut;
        hold_l = lastOut;
        repeat (3) @(negedge clock);
        check_val("stall_data", 32'(dataOut), 32'(hold_d));
        check_val("stall_last", 32'(lastOut), 32'(hold_l));
        @(posedge clock);
        #1;
        outReady = 1'b1;
        wait_idle(60);
        check_val("full_count", 32'(out_cnt - base), 32'd9);

        // Invalid symbols dropped between valid pairs
        base = out_cnt;
        push(7'h78, 8'd0);
        push(7'h05, 8'd2);
        push(7'h7F, 8'd0);
        push(7'h00, 8'd1);
        push(7'h78, 8'd0);
        idle_in();
        wait_idle(50);
        check_val("inv_count", 32'(out_cnt - base), 32'd2);
        check_val("inv_errFlag", 32'(errFlag), 32'd1);
        check_val("inv_dropCnt", 32'(dropCnt), 32'd3);
        for (int k = 0; k < 300; k++) push(7'h01, 8'd0);
        idle_in();
        @(negedge clock);
        check_val("sat_dropCnt", 32'(dropCnt), 32'd255);
        check_val("sat_busy", 32'(busy), 32'd0);

        // Maximum run length
        @(posedge clock);
        #1;
        base = out_cnt;
        push(7'h5A, 8'd255);
        idle_in();
        wait_idle(400);
        check_val("max_count", 32'(out_cnt - base), 32'd256);

        // Reset in the middle of a run
        base = out_cnt;
        push(7'h51, 8'd10);
        push(7'h52, 8'd2);
        idle_in();
        w = 0;
        while (out_cnt < base + 4 && w < 50) begin
            @(posedge clock);
            #1;
            w++;
        end
        check_val("midrst_q_seen", 32'(out_cnt - base), 32'd4);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check_val("midrst_outValid", 32'(outValid), 32'd0);
        check_val("midrst_busy", 32'(busy), 32'd0);
        check_val("midrst_lastOut", 32'(lastOut), 32'd0);
        check_val("midrst_dataOut", 32'(dataOut), 32'd0);
        check_val("midrst_inReady", 32'(inReady), 32'd0);
        check_val("midrst_dropCnt", 32'(dropCnt), 32'd0);
        reset = 1'b0;
        base = out_cnt;
        repeat (20) @(posedge clock);
        #1;
        check_val("post_rst_outputs", 32'(out_cnt - base), 32'd0);
        check_val("post_rst_outValid", 32'(outValid), 32'd0);
        check_val("post_rst_busy", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
